// File: rtl/uart_rx_cmd_ctrl_if.sv
// Command-controller bus: UART RX bytes in, regfile strobes out, TX bytes out.
// master = command controller side, slave = UART / regfile side.
//   RX_P_DATA_CMD/RX_D_VLD_CMD  received byte + one-cycle valid
//   RD_DATA_CMD/RD_D_VLD_CMD    regfile read data + one-cycle valid
//   TX_BUSY_CMD                 UART TX busy
//   WR_EN_CMD/RD_EN_CMD         regfile write / read strobes
//   ADDR_CMD/WR_DATA_CMD        regfile address / write data
//   TX_P_DATA_CMD/TX_D_VLD_CMD  byte to UART TX + valid (held until accepted)
//   CMD_ERR_CMD/BUSY_CMD        error pulse / frame in progress
interface uart_rx_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] RX_P_DATA_CMD;
  logic              RX_D_VLD_CMD;
  logic [DATA_W-1:0] RD_DATA_CMD;
  logic              RD_D_VLD_CMD;
  logic              TX_BUSY_CMD;
  logic              WR_EN_CMD;
  logic              RD_EN_CMD;
  logic [ADDR_W-1:0] ADDR_CMD;
  logic [DATA_W-1:0] WR_DATA_CMD;
  logic [DATA_W-1:0] TX_P_DATA_CMD;
  logic              TX_D_VLD_CMD;
  logic              CMD_ERR_CMD;
  logic              BUSY_CMD;

  modport master (
    input  RX_P_DATA_CMD,
    input  RX_D_VLD_CMD,
    input  RD_DATA_CMD,
    input  RD_D_VLD_CMD,
    input  TX_BUSY_CMD,
    output WR_EN_CMD,
    output RD_EN_CMD,
    output ADDR_CMD,
    output WR_DATA_CMD,
    output TX_P_DATA_CMD,
    output TX_D_VLD_CMD,
    output CMD_ERR_CMD,
    output BUSY_CMD
  );

  modport slave (
    output RX_P_DATA_CMD,
    output RX_D_VLD_CMD,
    output RD_DATA_CMD,
    output RD_D_VLD_CMD,
    output TX_BUSY_CMD,
    input  WR_EN_CMD,
    input  RD_EN_CMD,
    input  ADDR_CMD,
    input  WR_DATA_CMD,
    input  TX_P_DATA_CMD,
    input  TX_D_VLD_CMD,
    input  CMD_ERR_CMD,
    input  BUSY_CMD
  );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// UART command sequencer: decodes AA(write)/BB(read) frames from RX bytes,
// drives regfile strobes and returns read data to UART TX.
// Ports:
//   CLK_CMD_CTRL  clock, rising edge
//   RST_CMD_CTRL  asynchronous active-high reset
//   io_cmd        uart_rx_cmd_ctrl_if.master (RX in, regfile, TX, status)
// Optional feature: define CMD_TIMEOUT_EN to abort a stalled frame after
// TIMEOUT_CYC idle cycles (CMD_ERR pulse, back to IDLE, no strobe).
module uart_rx_cmd_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic CLK_CMD_CTRL,
  input  logic RST_CMD_CTRL,
  uart_rx_cmd_ctrl_if.master io_cmd
);

  localparam logic [DATA_W-1:0] OP_WR = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] OP_RD = DATA_W'(8'hBB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_TX_SEND
  } state_t;

  state_t            r_state;
  logic              r_wr_en;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_vld;
  logic              r_err;
  logic              r_busy;

  logic [DATA_W-1:0] w_rx_data;
  logic              w_rx_vld;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_vld;
  logic              w_tx_busy;

  assign w_rx_data = io_cmd.RX_P_DATA_CMD;
  assign w_rx_vld  = io_cmd.RX_D_VLD_CMD;
  assign w_rd_data = io_cmd.RD_DATA_CMD;
  assign w_rd_vld  = io_cmd.RD_D_VLD_CMD;
  assign w_tx_busy = io_cmd.TX_BUSY_CMD;

`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic             w_timed;
  logic             w_quiet;

  // TX_SEND is deliberately excluded: the TX side may stall indefinitely.
  assign w_timed = (r_state == S_WR_ADDR) || (r_state == S_WR_DATA) ||
                   (r_state == S_RD_ADDR) || (r_state == S_RD_WAIT);
  // A cycle is idle when nothing arrives that could advance the frame.
  assign w_quiet = !w_rx_vld &&
                   !((r_state == S_RD_WAIT) && w_rd_vld);
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge CLK_CMD_CTRL or posedge RST_CMD_CTRL) begin
    if (RST_CMD_CTRL) begin
      r_state   <= S_IDLE;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      r_to_cnt  <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_err   <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_rx_vld) begin
            if (w_rx_data == OP_WR) begin
              r_state <= S_WR_ADDR;
              r_busy  <= 1'b1;
            end else if (w_rx_data == OP_RD) begin
              r_state <= S_RD_ADDR;
              r_busy  <= 1'b1;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end

        S_WR_ADDR: begin
          if (w_rx_vld) begin
            r_addr  <= w_rx_data[ADDR_W-1:0];
            r_state <= S_WR_DATA;
          end
        end

        S_WR_DATA: begin
          if (w_rx_vld) begin
            r_wr_data <= w_rx_data;
            r_wr_en   <= 1'b1;
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
          end
        end

        S_RD_ADDR: begin
          if (w_rx_vld) begin
            r_addr  <= w_rx_data[ADDR_W-1:0];
            r_rd_en <= 1'b1;
            r_state <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          // Read data wins; a simultaneous RX byte is dropped.
          if (w_rd_vld) begin
            r_tx_data <= w_rd_data;
            r_tx_vld  <= 1'b1;
            r_state   <= S_TX_SEND;
          end
          if (w_rx_vld) begin
            r_err <= 1'b1;
          end
        end

        S_TX_SEND: begin
          if (r_tx_vld && !w_tx_busy) begin
            r_tx_vld <= 1'b0;
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
          end
          if (w_rx_vld) begin
            r_err <= 1'b1;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_tx_vld <= 1'b0;
        end
      endcase

`ifdef CMD_TIMEOUT_EN
      // Only fires on idle cycles, where the case above changed nothing,
      // so these later assignments never fight a real transition.
      if (w_timed && w_quiet) begin
        if (r_to_cnt == TO_LAST) begin
          r_to_cnt <= '0;
          r_err    <= 1'b1;
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
`endif
    end
  end

  assign io_cmd.WR_EN_CMD     = r_wr_en;
  assign io_cmd.RD_EN_CMD     = r_rd_en;
  assign io_cmd.ADDR_CMD      = r_addr;
  assign io_cmd.WR_DATA_CMD   = r_wr_data;
  assign io_cmd.TX_P_DATA_CMD = r_tx_data;
  assign io_cmd.TX_D_VLD_CMD  = r_tx_vld;
  assign io_cmd.CMD_ERR_CMD   = r_err;
  assign io_cmd.BUSY_CMD      = r_busy;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: directed frame scenarios plus random
// write/read/garbage traffic checked against a regfile reference model.
module tb_uart_rx_cmd_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_cmd_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  uart_rx_cmd_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(16)
  ) dut (
    .CLK_CMD_CTRL(clk),
    .RST_CMD_CTRL(rst),
    .io_cmd(bus.master)
  );

  int checks = 0;
  int failures = 0;

  int n_wr = 0;
  int n_rd = 0;
  int n_err = 0;
  int n_both = 0;

  logic [DW-1:0] mem_dut [16];
  logic [DW-1:0] ref_mem [16];

  // Regfile stand-in and strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.WR_EN_CMD) begin
      n_wr++;
      mem_dut[bus.ADDR_CMD] = bus.WR_DATA_CMD;
    end
    if (bus.RD_EN_CMD) n_rd++;
    if (bus.CMD_ERR_CMD) n_err++;
    if (bus.WR_EN_CMD && bus.RD_EN_CMD) n_both++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.RX_P_DATA_CMD = b;
    bus.RX_D_VLD_CMD = 1'b1;
    tick();
    bus.RX_D_VLD_CMD = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] a;
    rst = 1'b1;
    bus.RX_P_DATA_CMD = '0;
    bus.RX_D_VLD_CMD = 1'b0;
    bus.RD_DATA_CMD = '0;
    bus.RD_D_VLD_CMD = 1'b0;
    bus.TX_BUSY_CMD = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_dut[i] = '0;
      ref_mem[i] = '0;
    end
    tick();
    tick();
    checks++;
    if ({bus.WR_EN_CMD, bus.RD_EN_CMD, bus.TX_D_VLD_CMD,
         bus.CMD_ERR_CMD, bus.BUSY_CMD} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b want=00000",
        {bus.WR_EN_CMD, bus.RD_EN_CMD, bus.TX_D_VLD_CMD,
         bus.CMD_ERR_CMD, bus.BUSY_CMD});
    end
    a = {4'h0, bus.ADDR_CMD};
    checks++;
    if ({a, bus.WR_DATA_CMD, bus.TX_P_DATA_CMD} !== 24'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=000000",
        {a, bus.WR_DATA_CMD, bus.TX_P_DATA_CMD});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int w0;
    w0 = n_wr;
    send_byte(8'hAA); tick();
    send_byte(8'h05); tick();
    send_byte(8'h3C);
    checks++;
    if (bus.WR_EN_CMD !== 1'b1 || bus.ADDR_CMD !== 4'h5 ||
        bus.WR_DATA_CMD !== 8'h3C) begin
      failures++;
      $display("FAIL write_strobe got en=%b a=%h d=%h want en=1 a=5 d=3c",
        bus.WR_EN_CMD, bus.ADDR_CMD, bus.WR_DATA_CMD);
    end
    checks++;
    if (bus.BUSY_CMD !== 1'b0 || bus.RD_EN_CMD !== 1'b0) begin
      failures++;
      $display("FAIL write_busy got busy=%b rd=%b want 0 0",
        bus.BUSY_CMD, bus.RD_EN_CMD);
    end
    tick();
    checks++;
    if (bus.WR_EN_CMD !== 1'b0 || n_wr - w0 !== 1) begin
      failures++;
      $display("FAIL write_single got en=%b n=%0d want en=0 n=1",
        bus.WR_EN_CMD, n_wr - w0);
    end
    ref_mem[5] = 8'h3C;
  endtask

  task automatic test_read();
    int r0;
    r0 = n_rd;
    send_byte(8'hBB); tick();
    send_byte(8'h0A);
    checks++;
    if (bus.RD_EN_CMD !== 1'b1 || bus.ADDR_CMD !== 4'hA ||
        bus.BUSY_CMD !== 1'b1) begin
      failures++;
      $display("FAIL read_strobe got en=%b a=%h busy=%b want 1 a 1",
        bus.RD_EN_CMD, bus.ADDR_CMD, bus.BUSY_CMD);
    end
    bus.TX_BUSY_CMD = 1'b1;
    tick(); tick();
    bus.RD_DATA_CMD = 8'h77;
    bus.RD_D_VLD_CMD = 1'b1;
    tick();
    bus.RD_D_VLD_CMD = 1'b0;
    checks++;
    if (bus.TX_D_VLD_CMD !== 1'b1 || bus.TX_P_DATA_CMD !== 8'h77) begin
      failures++;
      $display("FAIL read_tx_rise got v=%b d=%h want 1 77",
        bus.TX_D_VLD_CMD, bus.TX_P_DATA_CMD);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.TX_D_VLD_CMD !== 1'b1 || bus.TX_P_DATA_CMD !== 8'h77) begin
        failures++;
        $display("FAIL read_tx_hold[%0d] got v=%b d=%h want 1 77",
          i, bus.TX_D_VLD_CMD, bus.TX_P_DATA_CMD);
      end
    end
    bus.TX_BUSY_CMD = 1'b0;
    tick();
    checks++;
    if (bus.TX_D_VLD_CMD !== 1'b0 || bus.BUSY_CMD !== 1'b0) begin
      failures++;
      $display("FAIL read_tx_drop got v=%b busy=%b want 0 0",
        bus.TX_D_VLD_CMD, bus.BUSY_CMD);
    end
    bus.RD_DATA_CMD = 8'h11;
    bus.RD_D_VLD_CMD = 1'b1;
    tick();
    bus.RD_D_VLD_CMD = 1'b0;
    tick();
    checks++;
    if (bus.TX_D_VLD_CMD !== 1'b0 || bus.BUSY_CMD !== 1'b0 ||
        n_rd - r0 !== 1) begin
      failures++;
      $display("FAIL read_stray got v=%b busy=%b n=%0d want 0 0 1",
        bus.TX_D_VLD_CMD, bus.BUSY_CMD, n_rd - r0);
    end
  endtask

  task automatic test_bad_opcode();
    send_byte(8'h12);
    checks++;
    if (bus.CMD_ERR_CMD !== 1'b1 || bus.BUSY_CMD !== 1'b0 ||
        bus.WR_EN_CMD !== 1'b0 || bus.RD_EN_CMD !== 1'b0) begin
      failures++;
      $display("FAIL bad_op got err=%b busy=%b wr=%b rd=%b want 1 0 0 0",
        bus.CMD_ERR_CMD, bus.BUSY_CMD, bus.WR_EN_CMD, bus.RD_EN_CMD);
    end
    tick();
    checks++;
    if (bus.CMD_ERR_CMD !== 1'b0) begin
      failures++;
      $display("FAIL bad_op_pulse got err=%b want 0", bus.CMD_ERR_CMD);
    end
    send_byte(8'hAA); tick();
    send_byte(8'h01); tick();
    send_byte(8'hFF);
    checks++;
    if (bus.WR_EN_CMD !== 1'b1 || bus.ADDR_CMD !== 4'h1 ||
        bus.WR_DATA_CMD !== 8'hFF) begin
      failures++;
      $display("FAIL bad_op_recover got en=%b a=%h d=%h want 1 1 ff",
        bus.WR_EN_CMD, bus.ADDR_CMD, bus.WR_DATA_CMD);
    end
    ref_mem[1] = 8'hFF;
    tick();
  endtask

  task automatic test_drop_rd_wait();
    send_byte(8'hBB); tick();
    send_byte(8'h03); tick();
    send_byte(8'h55);
    checks++;
    if (bus.CMD_ERR_CMD !== 1'b1 || bus.BUSY_CMD !== 1'b1) begin
      failures++;
      $display("FAIL drop_err got err=%b busy=%b want 1 1",
        bus.CMD_ERR_CMD, bus.BUSY_CMD);
    end
    bus.RD_DATA_CMD = 8'h5A;
    bus.RD_D_VLD_CMD = 1'b1;
    tick();
    bus.RD_D_VLD_CMD = 1'b0;
    checks++;
    if (bus.TX_D_VLD_CMD !== 1'b1 || bus.TX_P_DATA_CMD !== 8'h5A) begin
      failures++;
      $display("FAIL drop_tx got v=%b d=%h want 1 5a",
        bus.TX_D_VLD_CMD, bus.TX_P_DATA_CMD);
    end
    tick();
    checks++;
    if (bus.TX_D_VLD_CMD !== 1'b0 || bus.BUSY_CMD !== 1'b0) begin
      failures++;
      $display("FAIL drop_done got v=%b busy=%b want 0 0",
        bus.TX_D_VLD_CMD, bus.BUSY_CMD);
    end
    // Same-cycle RX byte and read data, then an RX byte during TX_SEND.
    send_byte(8'hBB);
    send_byte(8'h07); tick();
    bus.RD_DATA_CMD = 8'hC3;
    bus.RD_D_VLD_CMD = 1'b1;
    bus.TX_BUSY_CMD = 1'b1;
    send_byte(8'h33);
    bus.RD_D_VLD_CMD = 1'b0;
    checks++;
    if (bus.CMD_ERR_CMD !== 1'b1 || bus.TX_D_VLD_CMD !== 1'b1 ||
        bus.TX_P_DATA_CMD !== 8'hC3) begin
      failures++;
      $display("FAIL collide got err=%b v=%b d=%h want 1 1 c3",
        bus.CMD_ERR_CMD, bus.TX_D_VLD_CMD, bus.TX_P_DATA_CMD);
    end
    send_byte(8'hAA);
    checks++;
    if (bus.CMD_ERR_CMD !== 1'b1 || bus.TX_D_VLD_CMD !== 1'b1 ||
        bus.BUSY_CMD !== 1'b1) begin
      failures++;
      $display("FAIL tx_drop got err=%b v=%b busy=%b want 1 1 1",
        bus.CMD_ERR_CMD, bus.TX_D_VLD_CMD, bus.BUSY_CMD);
    end
    bus.TX_BUSY_CMD = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int w0;
    int e0;
    int hit;
    w0 = n_wr;
    e0 = n_err;
    send_byte(8'hAA); tick();
    send_byte(8'h02);
`ifdef CMD_TIMEOUT_EN
    hit = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (bus.CMD_ERR_CMD === 1'b1) begin
        hit = i;
        break;
      end
    end
    checks++;
    if (hit !== 16 || bus.BUSY_CMD !== 1'b0) begin
      failures++;
      $display("FAIL timeout got cyc=%0d busy=%b want 16 0",
        hit, bus.BUSY_CMD);
    end
    tick();
    checks++;
    if (n_wr !== w0 || n_err - e0 !== 1) begin
      failures++;
      $display("FAIL timeout_nowr got wr=%0d err=%0d want 0 1",
        n_wr - w0, n_err - e0);
    end
`else
    hit = 0;
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (bus.BUSY_CMD !== 1'b1 || n_err !== e0 || n_wr !== w0) begin
      failures++;
      $display("FAIL wait got busy=%b err=%0d wr=%0d want 1 0 0",
        bus.BUSY_CMD, n_err - e0, n_wr - w0);
    end
    send_byte(8'h6E);
    checks++;
    if (bus.WR_EN_CMD !== 1'b1 || bus.ADDR_CMD !== 4'h2 ||
        bus.WR_DATA_CMD !== 8'h6E || hit !== 0) begin
      failures++;
      $display("FAIL wait_write got en=%b a=%h d=%h want 1 2 6e",
        bus.WR_EN_CMD, bus.ADDR_CMD, bus.WR_DATA_CMD);
    end
    ref_mem[2] = 8'h6E;
    tick();
`endif
  endtask

  task automatic test_reset_midframe();
    int w0;
    w0 = n_wr;
    send_byte(8'hAA); tick();
    send_byte(8'h04);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.BUSY_CMD !== 1'b0 || bus.ADDR_CMD !== 4'h0 ||
        bus.WR_EN_CMD !== 1'b0) begin
      failures++;
      $display("FAIL async_rst got busy=%b a=%h en=%b want 0 0 0",
        bus.BUSY_CMD, bus.ADDR_CMD, bus.WR_EN_CMD);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (n_wr !== w0) begin
      failures++;
      $display("FAIL rst_nowr got wr=%0d want 0", n_wr - w0);
    end
    send_byte(8'hAA); tick();
    send_byte(8'h04); tick();
    send_byte(8'h99);
    checks++;
    if (bus.WR_EN_CMD !== 1'b1 || bus.ADDR_CMD !== 4'h4 ||
        bus.WR_DATA_CMD !== 8'h99) begin
      failures++;
      $display("FAIL rst_recover got en=%b a=%h d=%h want 1 4 99",
        bus.WR_EN_CMD, bus.ADDR_CMD, bus.WR_DATA_CMD);
    end
    ref_mem[4] = 8'h99;
    tick();
  endtask

  task automatic gap();
    int g;
    g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) tick();
  endtask

  task automatic test_random();
    int w0;
    int r0;
    int e0;
    int exp_wr;
    int exp_rd;
    int exp_err;
    int kind;
    int d;
    logic [7:0] a;
    logic [7:0] v;
    logic [7:0] got;
    logic done;
    w0 = n_wr;
    r0 = n_rd;
    e0 = n_err;
    exp_wr = 0;
    exp_rd = 0;
    exp_err = 0;
    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 4);
      a = 8'($urandom);
      v = 8'($urandom);
      if (kind <= 1) begin
        send_byte(8'hAA); gap();
        send_byte(a); gap();
        send_byte(v);
        ref_mem[a[3:0]] = v;
        exp_wr++;
      end else if (kind <= 3) begin
        send_byte(8'hBB); gap();
        send_byte(a);
        exp_rd++;
        checks++;
        if (bus.RD_EN_CMD !== 1'b1 || bus.ADDR_CMD !== a[3:0]) begin
          failures++;
          $display("FAIL rnd_rd_en[%0d] got en=%b a=%h want 1 %h",
            f, bus.RD_EN_CMD, bus.ADDR_CMD, a[3:0]);
        end
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) tick();
        bus.RD_DATA_CMD = mem_dut[bus.ADDR_CMD];
        bus.RD_D_VLD_CMD = 1'b1;
        tick();
        bus.RD_D_VLD_CMD = 1'b0;
        done = 1'b0;
        got = '0;
        for (int i = 0; i < 64 && !done; i++) begin
          bus.TX_BUSY_CMD = 1'($urandom_range(0, 1));
          if (bus.TX_D_VLD_CMD === 1'b1 && !bus.TX_BUSY_CMD) begin
            got = bus.TX_P_DATA_CMD;
            done = 1'b1;
          end
          tick();
        end
        bus.TX_BUSY_CMD = 1'b0;
        checks++;
        if (!done || got !== ref_mem[a[3:0]]) begin
          failures++;
          $display("FAIL rnd_rd_data[%0d] got done=%b d=%h want 1 %h",
            f, done, got, ref_mem[a[3:0]]);
        end
      end else begin
        do v = 8'($urandom); while (v == 8'hAA || v == 8'hBB);
        send_byte(v);
        exp_err++;
      end
      gap();
    end
    tick();
    tick();
    checks++;
    if (n_wr - w0 !== exp_wr || n_rd - r0 !== exp_rd ||
        n_err - e0 !== exp_err) begin
      failures++;
      $display("FAIL rnd_counts got wr=%0d rd=%0d err=%0d want %0d %0d %0d",
        n_wr - w0, n_rd - r0, n_err - e0, exp_wr, exp_rd, exp_err);
    end
    checks++;
    if (n_both !== 0) begin
      failures++;
      $display("FAIL rnd_overlap got=%0d want 0", n_both);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem_dut[i] !== ref_mem[i]) begin
        failures++;
        $display("FAIL rnd_mem[%0d] got=%h want=%h",
          i, mem_dut[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_drop_rd_wait();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
